cordic_vec_controller: RTL and testbench

//   Sequencer for the CORDIC vectoring-mode datapath: on start, loads x/y/z, runs
//   NUM_ITER micro-rotations, then reports done. Per iteration it drives the

---
 rtl/cordic_pkg.sv | 19 +
 rtl/cordic_vec_controller.sv | 120 ++++++++++++
 tb/tb_cordic_vec_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC vectoring-mode controller: state encoding,
// default sizing and the CORDIC gain constant.
package cordic_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        GAIN = 3'd3,
        DONE = 3'd4
    } cordic_state_t;

    localparam int DEFAULT_ADDRESS_LENGTH = 4;
    localparam int DEFAULT_NUM_ITER       = 14;

    // K ~= 0.6073 in Q2.14
    localparam logic [15:0] CORDIC_GAIN = 16'h26DD;

endpackage

// File: rtl/cordic_vec_controller.sv
// Sequencer for the CORDIC vectoring-mode datapath and arctan ROM.
// Optional gain-compensation state enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_vec_controller
    import cordic_pkg::*;
#(
    parameter int ADDRESS_LENGTH = DEFAULT_ADDRESS_LENGTH,
    parameter int NUM_ITER       = DEFAULT_NUM_ITER
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      y_sign,
    output logic                      busy,
    output logic                      load_en,
    output logic                      iter_en,
    output logic                      dir,
    output logic [ADDRESS_LENGTH-1:0] shift_amt,
    output logic                      rom_read_enable,
    output logic [ADDRESS_LENGTH-1:0] rom_address,
`ifdef CORDIC_GAIN_COMP_EN
    output logic                      gain_en,
`endif
    output logic                      done
);

    if (NUM_ITER < 1 || NUM_ITER > (1 << ADDRESS_LENGTH)) begin : g_bad_num_iter
        $error("cordic_vec_controller: NUM_ITER out of range 1..2**ADDRESS_LENGTH");
    end

    localparam logic [ADDRESS_LENGTH-1:0] LAST_ITER = ADDRESS_LENGTH'(NUM_ITER - 1);

    cordic_state_t             state;
    logic [ADDRESS_LENGTH-1:0] counter;

    // Outputs are registered as decodes of the next state; the counter is held
    // at zero outside ITER so it can drive shift_amt/rom_address directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            counter         <= '0;
            busy            <= 1'b0;
            load_en         <= 1'b0;
            iter_en         <= 1'b0;
            rom_read_enable <= 1'b0;
            done            <= 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
            gain_en         <= 1'b0;
`endif
        end else begin
            busy            <= 1'b1;
            load_en         <= 1'b0;
            iter_en         <= 1'b0;
            rom_read_enable <= 1'b0;
            done            <= 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
            gain_en         <= 1'b0;
`endif
            if (abort) begin
                state   <= IDLE;
                counter <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= LOAD;
                            load_en <= 1'b1;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    LOAD: begin
                        state           <= ITER;
                        counter         <= '0;
                        iter_en         <= 1'b1;
                        rom_read_enable <= 1'b1;
                    end
                    ITER: begin
                        if (counter == LAST_ITER) begin
                            counter <= '0;
`ifdef CORDIC_GAIN_COMP_EN
                            state   <= GAIN;
                            gain_en <= 1'b1;
`else
                            state   <= DONE;
                            done    <= 1'b1;
`endif
                        end else begin
                            counter         <= counter + 1'b1;
                            iter_en         <= 1'b1;
                            rom_read_enable <= 1'b1;
                        end
                    end
                    GAIN: begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                    DONE: begin
                        state   <= IDLE;
                        counter <= '0;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        counter <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign shift_amt   = counter;
    assign rom_address = counter;

    // Rotate toward y = 0; follows the datapath's y sign within the same cycle.
    assign dir = iter_en & ~y_sign;

endmodule

// File: tb/tb_cordic_vec_controller.sv
// Directed self-checking bench for cordic_vec_controller (NUM_ITER=14 and NUM_ITER=1).
module tb_cordic_vec_controller;

    localparam int AL = 4;
    localparam int NI = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          y_sign = 1'b0;
    logic          busy, load_en, iter_en, dir, rom_read_enable, done;
    logic [AL-1:0] shift_amt, rom_address;
    logic          gain_en;

    logic          start2 = 1'b0;
    logic          busy2, load_en2, iter_en2, dir2, rom_read_enable2, done2;
    logic [AL-1:0] shift_amt2, rom_address2;
    logic          gain_en2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cordic_vec_controller #(.ADDRESS_LENGTH(AL), .NUM_ITER(NI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_sign(y_sign),
        .busy(busy), .load_en(load_en), .iter_en(iter_en), .dir(dir),
        .shift_amt(shift_amt), .rom_read_enable(rom_read_enable),
        .rom_address(rom_address),
`ifdef CORDIC_GAIN_COMP_EN
        .gain_en(gain_en),
`endif
        .done(done)
    );

    cordic_vec_controller #(.ADDRESS_LENGTH(AL), .NUM_ITER(1)) dut_one (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .y_sign(1'b0),
        .busy(busy2), .load_en(load_en2), .iter_en(iter_en2), .dir(dir2),
        .shift_amt(shift_amt2), .rom_read_enable(rom_read_enable2),
        .rom_address(rom_address2),
`ifdef CORDIC_GAIN_COMP_EN
        .gain_en(gain_en2),
`endif
        .done(done2)
    );

`ifndef CORDIC_GAIN_COMP_EN
    assign gain_en  = 1'b0;
    assign gain_en2 = 1'b0;
`endif

    // Arctan ROM, atan(2^-i) scaled so that 45 degrees = 0x2000.
    function automatic logic [15:0] atan_rom(input logic [AL-1:0] a);
        case (a)
            4'd0:  return 16'h2000;
            4'd1:  return 16'h12E4;
            4'd2:  return 16'h09FB;
            4'd3:  return 16'h0511;
            4'd4:  return 16'h028B;
            4'd5:  return 16'h0146;
            4'd6:  return 16'h00A3;
            4'd7:  return 16'h0051;
            4'd8:  return 16'h0029;
            4'd9:  return 16'h0014;
            4'd10: return 16'h000A;
            4'd11: return 16'h0005;
            4'd12: return 16'h0003;
            4'd13: return 16'h0001;
            default: return 16'h0000;
        endcase
    endfunction

    logic [15:0] rom_q;
    always_comb rom_q = rom_read_enable ? atan_rom(rom_address) : 16'h0000;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_op(input int abort_at, input bit toggle);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        y_sign = 1'b0;
        #1;
        check("load_en", load_en, 1);
        check("load_busy", busy, 1);
        check("load_dir", dir, 0);
        check("load_iter_en", iter_en, 0);
        check("load_gain_en", gain_en, 0);
        for (int k = 0; k < NI; k++) begin
            @(negedge clk);
            y_sign = toggle ? k[0] : 1'b0;
            #1;
            check($sformatf("iter_en[%0d]", k), iter_en, 1);
            check($sformatf("rom_address[%0d]", k), rom_address, k);
            check($sformatf("shift_amt[%0d]", k), shift_amt, k);
            check($sformatf("rom_re[%0d]", k), rom_read_enable, 1);
            check($sformatf("dir[%0d]", k), dir, (toggle && k[0]) ? 0 : 1);
            check($sformatf("iter_done[%0d]", k), done, 0);
            if (k == 0)      check("rom_q_first", rom_q, 16'h2000);
            if (k == 1)      check("rom_q_second", rom_q, 16'h12E4);
            if (k == NI - 1) check("rom_q_last", rom_q, 16'h0001);
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk) abort = 1'b0;
                y_sign = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_iter_en", iter_en, 0);
                check("abort_rom_address", rom_address, 0);
                for (int j = 0; j < 20; j++) begin
                    @(negedge clk); #1;
                    if (done) check("abort_no_done", done, 0);
                end
                check("abort_idle_busy", busy, 0);
                return;
            end
        end
        y_sign = 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
        @(negedge clk); #1;
        check("gain_en", gain_en, 1);
        check("gain_done", done, 0);
        check("gain_iter_en", iter_en, 0);
`endif
        @(negedge clk); #1;
        check("done", done, 1);
        check("done_busy", busy, 1);
        check("done_iter_en", iter_en, 0);
        check("done_dir", dir, 0);
        check("done_rom_re", rom_read_enable, 0);
        check("done_rom_address", rom_address, 0);
        check("done_gain_en", gain_en, 0);
        @(negedge clk); #1;
        check("post_done", done, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        int t, d1, d2;

        // Reset with start asserted
        start = 1'b1;
        y_sign = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {busy, load_en, iter_en, dir, shift_amt, rom_read_enable, rom_address, done, gain_en}, 0);
        start = 1'b0;
        y_sign = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_load_en", load_en, 0);
        check("idle_dir", dir, 0);

        // Nominal, y_sign held 0
        run_op(-1, 1'b0);
        // Direction tracking with toggling y_sign
        run_op(-1, 1'b1);
        // Abort at counter 5, then a full run
        run_op(5, 1'b0);
        run_op(-1, 1'b0);

        // start held high: back-to-back operations
        @(negedge clk) start = 1'b1;
        t = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && t < 100) begin
            @(negedge clk); #1;
            t++;
            if (d1 >= 0 && t == d1 + 1) begin
                check("b2b_done_start_ignored", load_en, 0);
                check("b2b_idle_busy", busy, 0);
            end
            if (d1 >= 0 && t == d1 + 2) check("b2b_reload", load_en, 1);
            if (done) begin
                if (d1 < 0) d1 = t;
                else d2 = t;
            end
        end
        start = 1'b0;
        check("b2b_first_done_seen", (d1 >= 0) ? 1 : 0, 1);
        check("b2b_period", d2 - d1, NI + 3 + EXTRA);
        repeat (2) @(negedge clk);
        #1;
        check("b2b_drained", busy, 0);

        // Reset asserted mid-operation
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_iter_en", iter_en, 0);
        check("midreset_rom_address", rom_address, 0);
        @(negedge clk) rst_n = 1'b1;
        t = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (done) t++;
        end
        check("midreset_no_done", t, 0);
        check("midreset_idle", busy, 0);

        // NUM_ITER = 1 instance
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        #1;
        check("one_load_en", load_en2, 1);
        @(negedge clk); #1;
        check("one_iter_en", iter_en2, 1);
        check("one_rom_address", rom_address2, 0);
        check("one_dir", dir2, 1);
`ifdef CORDIC_GAIN_COMP_EN
        @(negedge clk); #1;
        check("one_gain_en", gain_en2, 1);
        check("one_gain_iter_en", iter_en2, 0);
`endif
        @(negedge clk); #1;
        check("one_done", done2, 1);
        check("one_done_iter_en", iter_en2, 0);
        @(negedge clk); #1;
        check("one_idle", busy2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
